json_view_packer: RTL and testbench
===================================

Name: json_view_packer

Overview:
- Parametrised successor to the single-format RGB565-to-JSON byte serializer.
- Packs NUM_VIEWS camera views into one JSON object: {"1":"<data>",\n"2":"<data>"...}.
- Each view is WORDS_PER_VIEW input words of WORD_BYTES bytes.
- Adds valid/ready handshakes on both sides, output backpressure, a selectable raw/hex payload mode and per-view/file status pulses.
- Sits between the frame-buffer reader (upstream) and the network/UART byte sink (downstream).

Parameters:
WORD_BYTES, 8, bytes per input word (3 RGB565 pixels + pad by default); legal 1..16
WORDS_PER_VIEW, 102400, input words per view (640*480/3); must be >= 1
NUM_VIEWS, 3, views per file; legal 1..9 (single ASCII digit)
CNT_W, 17, word-counter width; must satisfy 2^CNT_W > WORDS_PER_VIEW-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a file; ignored unless busy=0
hex_mode  in  1  0: raw payload bytes; 1: each byte emitted as two lowercase ASCII hex chars; sampled only on accepted start
in_valid  in  1  in_data valid
in_ready  out  1  word accepted when in_valid&in_ready
in_data  in  8*WORD_BYTES  payload word; MSB byte emitted first
out_valid  out  1  out_data valid
out_ready  in  1  byte consumed when out_valid&out_ready
out_data  out  8  output byte
view_done  out  1  one-cycle pulse when a view's closing quote is consumed
file_done  out  1  one-cycle pulse when the closing '}' is consumed
busy  out  1  high from accepted start until file_done cycle inclusive
cur_view  out  4  current view number 1..NUM_VIEWS; 0 when idle

Behaviour:
- Reset: rst_n sampled low at any rising edge returns FSM to IDLE.
  - Reset values: out_valid=0, out_data=0, in_ready=0, view_done=0, file_done=0, busy=0, cur_view=0.
  - Clears all counters and the shift buffer; a partial file is discarded, with no closing bytes.
- Output register: once out_valid=1, out_data is held stable until out_ready=1. A new byte may be loaded in the same cycle the current one is consumed, giving 1 byte/clk sustained.
- FSM states:
  - IDLE: start=1 -> OPEN; latch hex_mode; cur_view<=1; busy<=1.
  - OPEN: emit '{' (0x7B) -> VHDR.
  - VHDR: emit '"', ASCII digit (0x30+cur_view), '"', ':', '"' -> DATA. Uses a 3-bit header index.
  - DATA: in_ready=1 only when the shift buffer is empty.
    - On accept, load in_data and emit its bytes MSB first: WORD_BYTES bytes raw, or 2*WORD_BYTES hex chars with the high nibble first ('0'-'9', 'a'-'f').
    - When the final byte of word WORDS_PER_VIEW-1 is consumed -> VTAIL; word counter resets to 0.
  - VTAIL: emit '"', pulse view_done on its consumption.
    - If cur_view<NUM_VIEWS: also emit ',' (0x2C) then '\n' (0x0A), cur_view+=1, -> VHDR.
    - Else -> CLOSE.
  - CLOSE: emit '}' (0x7D); on consumption pulse file_done, busy<=0, cur_view<=0 -> IDLE.
- Input never accepted outside DATA; in_valid without in_ready holds data upstream. No words dropped, none duplicated.
- An in_valid gap inside DATA produces an out_valid gap with no filler bytes.
- start while busy=1 has no effect. start and the file_done cycle coincident: start ignored (busy still 1).
- Output byte count per file:
  - Raw mode: 2 + NUM_VIEWS*(6+WORDS_PER_VIEW*WORD_BYTES) + 2*(NUM_VIEWS-1).
  - Hex mode: payload term doubled.
- Word counter saturates at no point; it wraps to 0 exactly at view end.

Test Plan:
- WORD_BYTES=2, WORDS_PER_VIEW=2, NUM_VIEWS=2, raw mode, out_ready=1. Words 0x4142,0x4344,0x4546,0x4748 -> stream {"1":"ABCD",\n"2":"EFGH"} (24 bytes). view_done pulses twice; file_done once, on '}'.
- Same config, hex_mode=1, same data -> {"1":"41424344",\n"2":"45464748"} (32 bytes). Hex letters lowercase: word 0xABCD -> "abcd".
- Random out_ready (50%) and random in_valid gaps -> byte stream identical to the first test. out_data never changes while out_valid=1 and out_ready=0.
- NUM_VIEWS=1, WORDS_PER_VIEW=1, WORD_BYTES=1, data 0x5A -> {"1":"Z"} with no ',' or '\n'. busy falls the cycle after file_done.
- rst_n low for 1 cycle mid-DATA of view 2 -> next cycle all outputs 0 and FSM in IDLE. A subsequent start produces a complete fresh file beginning with '{'.
- start pulsed again mid-file and coincident with the file_done cycle -> ignored; exactly one file emitted.

Source files
------------

// File: rtl/json_view_packer.sv
// json_view_packer: packs NUM_VIEWS camera views into one JSON byte stream
// {"1":"<data>",\n"2":"<data>"...} with valid/ready on both sides.
module json_view_packer #(
  parameter int WORD_BYTES     = 8,
  parameter int WORDS_PER_VIEW = 102400,
  parameter int NUM_VIEWS      = 3,
  parameter int CNT_W          = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    hex_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*WORD_BYTES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic                    view_done,
  output logic                    file_done,
  output logic                    busy,
  output logic [3:0]              cur_view
);

  localparam int DW   = 8 * WORD_BYTES;
  localparam int BC_W = $clog2(2 * WORD_BYTES + 1);

  typedef enum logic [2:0] {S_IDLE, S_OPEN, S_VHDR, S_DATA, S_VTAIL, S_CLOSE} state_t;

  state_t            state_r, state_nx_s;
  logic [7:0]        out_data_r;
  logic              out_valid_r, out_vq_r, out_cl_r;
  logic              view_done_r, file_done_r, busy_r, hex_r;
  logic [3:0]        cur_view_r;
  logic [2:0]        hdr_idx_r;
  logic [1:0]        tail_idx_r;
  logic [DW-1:0]     buf_r;
  logic [BC_W-1:0]   buf_cnt_r;
  logic [CNT_W-1:0]  word_cnt_r;

  logic              have_byte_s, tag_vq_s, tag_cl_s;
  logic [7:0]        byte_s;
  logic              load_s, take_s, accept_s, start_acc_s, in_ready_s;
  logic              last_char_s, last_word_s, last_view_s;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = 8'h57 + {4'h0, n};
  endfunction

  assign in_ready_s  = (state_r == S_DATA) && (buf_cnt_r == {BC_W{1'b0}});
  assign accept_s    = in_valid & in_ready_s;
  assign take_s      = out_valid_r & out_ready;
  assign load_s      = have_byte_s & (~out_valid_r | out_ready);
  assign start_acc_s = (state_r == S_IDLE) & start & ~busy_r;
  assign last_char_s = (buf_cnt_r == BC_W'(1));
  assign last_word_s = (word_cnt_r == CNT_W'(WORDS_PER_VIEW - 1));
  assign last_view_s = (cur_view_r == 4'(NUM_VIEWS));

  // Selects the next byte to present and tags view-closing quote / final brace.
  always_comb begin
    have_byte_s = 1'b0;
    byte_s      = 8'h00;
    tag_vq_s    = 1'b0;
    tag_cl_s    = 1'b0;
    case (state_r)
      S_OPEN: begin
        have_byte_s = 1'b1;
        byte_s      = 8'h7B;
      end
      S_VHDR: begin
        have_byte_s = 1'b1;
        case (hdr_idx_r)
          3'd1:    byte_s = 8'h30 + {4'h0, cur_view_r};
          3'd3:    byte_s = 8'h3A;
          default: byte_s = 8'h22;
        endcase
      end
      S_DATA: begin
        have_byte_s = (buf_cnt_r != {BC_W{1'b0}});
        byte_s      = hex_r ? hex_char(buf_r[DW-1 -: 4]) : buf_r[DW-1 -: 8];
      end
      S_VTAIL: begin
        have_byte_s = 1'b1;
        tag_vq_s    = (tail_idx_r == 2'd0);
        case (tail_idx_r)
          2'd1:    byte_s = 8'h2C;
          2'd2:    byte_s = 8'h0A;
          default: byte_s = 8'h22;
        endcase
      end
      S_CLOSE: begin
        have_byte_s = 1'b1;
        byte_s      = 8'h7D;
        tag_cl_s    = 1'b1;
      end
      default: have_byte_s = 1'b0;
    endcase
  end

  // Next-state logic; states advance when their byte is loaded into the output register.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:  if (start_acc_s) state_nx_s = S_OPEN; else state_nx_s = S_IDLE;
      S_OPEN:  if (load_s) state_nx_s = S_VHDR; else state_nx_s = S_OPEN;
      S_VHDR:  if (load_s && hdr_idx_r == 3'd4) state_nx_s = S_DATA; else state_nx_s = S_VHDR;
      S_DATA:  if (load_s && last_char_s && last_word_s) state_nx_s = S_VTAIL;
               else state_nx_s = S_DATA;
      S_VTAIL: if (load_s && tail_idx_r == 2'd0 && last_view_s) state_nx_s = S_CLOSE;
               else if (load_s && tail_idx_r == 2'd2) state_nx_s = S_VHDR;
               else state_nx_s = S_VTAIL;
      S_CLOSE: if (load_s) state_nx_s = S_IDLE; else state_nx_s = S_CLOSE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // Output register, status pulses, counters and the word shift buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      out_vq_r    <= 1'b0;
      out_cl_r    <= 1'b0;
      view_done_r <= 1'b0;
      file_done_r <= 1'b0;
      busy_r      <= 1'b0;
      hex_r       <= 1'b0;
      cur_view_r  <= 4'd0;
      hdr_idx_r   <= 3'd0;
      tail_idx_r  <= 2'd0;
      buf_r       <= {DW{1'b0}};
      buf_cnt_r   <= {BC_W{1'b0}};
      word_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (load_s) begin
        out_data_r  <= byte_s;
        out_valid_r <= 1'b1;
        out_vq_r    <= tag_vq_s;
        out_cl_r    <= tag_cl_s;
      end else if (take_s) begin
        out_valid_r <= 1'b0;
      end
      view_done_r <= take_s & out_vq_r;
      file_done_r <= take_s & out_cl_r;

      // busy drops one cycle after the file_done pulse so a coincident start is ignored
      if (start_acc_s) begin
        busy_r     <= 1'b1;
        hex_r      <= hex_mode;
        cur_view_r <= 4'd1;
      end else if (file_done_r) begin
        busy_r <= 1'b0;
      end
      if (take_s && out_cl_r) cur_view_r <= 4'd0;
      if (load_s && state_r == S_VTAIL && tail_idx_r == 2'd2) cur_view_r <= cur_view_r + 4'd1;

      if (load_s && state_r == S_VHDR)
        hdr_idx_r <= (hdr_idx_r == 3'd4) ? 3'd0 : hdr_idx_r + 3'd1;
      if (load_s && state_r == S_VTAIL)
        tail_idx_r <= ((tail_idx_r == 2'd0 && last_view_s) || tail_idx_r == 2'd2) ?
                      2'd0 : tail_idx_r + 2'd1;

      if (accept_s) begin
        buf_r     <= in_data;
        buf_cnt_r <= hex_r ? BC_W'(2 * WORD_BYTES) : BC_W'(WORD_BYTES);
      end else if (load_s && state_r == S_DATA) begin
        buf_r     <= hex_r ? (buf_r << 3'd4) : (buf_r << 4'd8);
        buf_cnt_r <= buf_cnt_r - BC_W'(1);
        if (last_char_s)
          word_cnt_r <= last_word_s ? {CNT_W{1'b0}} : word_cnt_r + CNT_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign view_done = view_done_r;
  assign file_done = file_done_r;
  assign busy      = busy_r;
  assign cur_view  = cur_view_r;

endmodule

// File: tb/tb_json_view_packer.sv
// Scoreboard bench for json_view_packer: 2x2x2 instance for the main tests,
// plus a 1x1x1 instance for the single-view corner case.
module tb_json_view_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, hex_mode, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [7:0]  out_data;
  logic        view_done, file_done, busy;
  logic [3:0]  cur_view;

  logic        start1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0]  in_data1, out_data1;
  logic        view_done1, file_done1, busy1;
  logic [3:0]  cur_view1;

  json_view_packer #(.WORD_BYTES(2), .WORDS_PER_VIEW(2), .NUM_VIEWS(2), .CNT_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hex_mode(hex_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .view_done(view_done), .file_done(file_done), .busy(busy), .cur_view(cur_view));

  json_view_packer #(.WORD_BYTES(1), .WORDS_PER_VIEW(1), .NUM_VIEWS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .hex_mode(1'b0),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .view_done(view_done1), .file_done(file_done1), .busy(busy1), .cur_view(cur_view1));

  typedef struct {logic [7:0] b; bit vq; bit cl;} exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int bytes_seen, vd_cnt, fd_cnt;
  bit sb_en = 1'b1, rnd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_str(input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.b  = s[i];
      e.vq = (s[i] == 8'h22) && (i + 1 < s.len()) && (s[i+1] == 8'h2C || s[i+1] == 8'h7D);
      e.cl = (s[i] == 8'h7D);
      exp_q.push_back(e);
    end
  endtask

  // Output-side ready driver (random when rnd=1).
  initial forever begin
    @(posedge clk); #1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every consumed byte; checks hold and pulses.
  initial begin
    bit pv = 0, pr = 0, pend_vq = 0, pend_cl = 0, prev_fd = 0;
    logic [7:0] pd = 8'h00;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; pend_vq = 0; pend_cl = 0; prev_fd = 0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if (!out_valid || out_data !== pd) begin
            failures++;
            $display("FAIL hold actual=%0h/%0b required=%0h/1", out_data, out_valid, pd);
          end
        end
        if (sb_en) begin
          if (view_done || pend_vq) chk("view_done_pulse", view_done, pend_vq);
          if (file_done || pend_cl) chk("file_done_pulse", file_done, pend_cl);
          if (file_done) chk("busy_in_fd_cycle", busy, 1);
          if (prev_fd) chk("idle_after_fd", {busy, cur_view}, 0);
          vd_cnt += view_done;
          fd_cnt += file_done;
        end
        prev_fd = sb_en && file_done;
        pend_vq = 0; pend_cl = 0;
        if (sb_en && out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_byte actual=%0h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            bytes_seen++;
            if (out_data !== e.b) begin
              failures++;
              $display("FAIL byte%0d actual=%0h required=%0h", bytes_seen, out_data, e.b);
            end
            pend_vq = e.vq; pend_cl = e.cl;
          end
        end
        pv = out_valid; pr = out_ready; pd = out_data;
      end
    end
  end

  task automatic start_pulse(input bit h);
    @(posedge clk); #1; start = 1'b1; hex_mode = h;
    @(posedge clk); #1; start = 1'b0; hex_mode = 1'b0;
  endtask

  task automatic feed(input logic [15:0] w, input bit gaps);
    bit ok = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = w;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("in_accept_timeout", 0, 1);
  endtask

  task automatic run_file(input bit h, input logic [15:0] w0, w1, w2, w3,
                          input bit gaps, input bit poke, input string s);
    bit done = 0;
    push_str(s);
    bytes_seen = 0; vd_cnt = 0; fd_cnt = 0;
    start_pulse(h);
    feed(w0, gaps); feed(w1, gaps);
    if (poke) start_pulse(~h);
    feed(w2, gaps); feed(w3, gaps);
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (poke && file_done) begin
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end
      done = !busy && exp_q.size() == 0;
    end
    chk("file_timeout", done, 1);
    @(negedge clk);
    chk("byte_count", bytes_seen, s.len());
    chk("view_done_count", vd_cnt, 2);
    chk("file_done_count", fd_cnt, 1);
  endtask

  initial begin
    string s1;
    logic [7:0] got1[$];
    bit fd1 = 0, ok1 = 0;
    rst_n = 0; start = 0; hex_mode = 0; in_valid = 0; in_data = 16'h0000; out_ready = 1;
    start1 = 0; in_valid1 = 0; in_data1 = 8'h00; out_ready1 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pulses", {view_done, file_done}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_view", cur_view, 0);
    @(posedge clk); #1; rst_n = 1;

    run_file(0, 16'h4142, 16'h4344, 16'h4546, 16'h4748, 0, 0,
             "{\"1\":\"ABCD\",\n\"2\":\"EFGH\"}");
    run_file(1, 16'h4142, 16'h4344, 16'h4546, 16'h4748, 0, 0,
             "{\"1\":\"41424344\",\n\"2\":\"45464748\"}");
    run_file(1, 16'hABCD, 16'hEF01, 16'h2345, 16'h6789, 0, 0,
             "{\"1\":\"abcdef01\",\n\"2\":\"23456789\"}");
    rnd = 1;
    run_file(0, 16'h4142, 16'h4344, 16'h4546, 16'h4748, 1, 0,
             "{\"1\":\"ABCD\",\n\"2\":\"EFGH\"}");
    rnd = 0;

    // Abort mid-DATA of view 2 with a one-cycle reset.
    sb_en = 0;
    start_pulse(0);
    feed(16'h4142, 0); feed(16'h4344, 0);
    for (int c = 0; c < 200 && cur_view != 4'd2; c++) @(negedge clk);
    chk("reached_view2", cur_view, 2);
    feed(16'h4546, 0);
    @(posedge clk); #1; rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    chk("abort_outputs", {out_valid, out_data, in_ready, view_done, file_done, busy, cur_view}, 0);
    exp_q.delete();
    sb_en = 1;
    run_file(0, 16'h4142, 16'h4344, 16'h4546, 16'h4748, 0, 0,
             "{\"1\":\"ABCD\",\n\"2\":\"EFGH\"}");

    // Extra start pulses mid-file and on the file_done cycle must be ignored.
    run_file(0, 16'h4142, 16'h4344, 16'h4546, 16'h4748, 0, 1,
             "{\"1\":\"ABCD\",\n\"2\":\"EFGH\"}");
    repeat (30) @(negedge clk);
    chk("no_second_file", {busy, out_valid}, 0);

    // Single view, single one-byte word.
    s1 = "{\"1\":\"Z\"}";
    @(posedge clk); #1; start1 = 1;
    @(posedge clk); #1; start1 = 0; in_valid1 = 1; in_data1 = 8'h5A;
    for (int c = 0; c < 100 && !ok1; c++) begin
      @(negedge clk);
      if (fd1) begin
        chk("single_busy_fall", busy1, 0);
        ok1 = 1;
      end
      if (file_done1) begin
        chk("single_busy_fd", busy1, 1);
        fd1 = 1;
      end
      if (out_valid1 && out_ready1) got1.push_back(out_data1);
      if (in_valid1 && in_ready1) begin
        @(posedge clk); #1; in_valid1 = 0;
      end
    end
    chk("single_done", ok1, 1);
    chk("single_len", got1.size(), s1.len());
    for (int i = 0; i < s1.len() && i < got1.size(); i++) chk("single_byte", got1[i], s1[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
